// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM state encoding,
// the default grant hold limit and a one-hot helper.
package mux_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned MAX_HOLD_DEFAULT = 8;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Request/data/grant bundle between four sources and the mux arbiter.
interface mux_rr_arbiter_if #(
  parameter int unsigned W = 4
);
  logic [3:0]   req;
  logic [W-1:0] D0;
  logic [W-1:0] D1;
  logic [W-1:0] D2;
  logic [W-1:0] D3;
  logic [3:0]   grant;
  logic [1:0]   sel;
  logic [W-1:0] Y;
  logic         y_valid;

  modport master (
    output req, D0, D1, D2, D3,
    input  grant, sel, Y, y_valid
  );

  modport slave (
    input  req, D0, D1, D2, D3,
    output grant, sel, Y, y_valid
  );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping from 3 back to 0.
module rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] idx,
  output logic       any
);

  logic [1:0] cand;
  logic       found;

  always_comb begin
    idx   = '0;
    any   = |req;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      cand = ptr + k[1:0];
      if (req[cand] && !found) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-source round-robin arbiter with registered grant/sel and muxed data.
// Optional grant timeout enabled by defining MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int unsigned W        = 4,
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  mux_rr_arbiter_if.slave  bus
);

  arb_state_e   state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [3:0]   grant_q, grant_d;
  logic [1:0]   sel_q, sel_d;
  logic [W-1:0] y_q, y_d;
  logic         yv_q, yv_d;

  logic [1:0]   pick_idx;
  logic         pick_any;
  logic [W-1:0] d_sel;
  logic         timeout;
  logic         leave;

  rr_pick u_rr_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    d_sel = '0;
    case (sel_q)
      2'd0: d_sel = bus.D0;
      2'd1: d_sel = bus.D1;
      2'd2: d_sel = bus.D2;
      2'd3: d_sel = bus.D3;
      default: d_sel = '0;
    endcase
  end

  assign leave = (state_q == GRANT) && (!bus.req[sel_q] || timeout);

`ifdef MUX_ARB_TIMEOUT_EN
  // Counts completed GRANT cycles; timeout fires on the MAX_HOLD-th one.
  localparam int unsigned HW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  logic [HW-1:0] hold_q, hold_d;

  assign timeout = (hold_q == HW'(MAX_HOLD - 1));

  always_comb begin
    hold_d = '0;
    if (state_q == GRANT && !leave) hold_d = hold_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    y_d     = '0;
    yv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        sel_d   = '0;
        if (pick_any) begin
          state_d = GRANT;
          grant_d = onehot4(pick_idx);
          sel_d   = pick_idx;
          ptr_d   = pick_idx + 2'd1;
        end
      end
      GRANT: begin
        y_d  = d_sel;
        yv_d = 1'b1;
        if (leave) begin
          state_d = IDLE;
          grant_d = '0;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.sel     = sel_q;
  assign bus.Y       = y_q;
  assign bus.y_valid = yv_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus random
// traffic against a cycle-level ownership model.
module tb_mux_rr_arbiter;

  localparam int unsigned W  = 4;
  localparam int unsigned MH = 3;

  logic clk = 1'b0;
  logic reset;

  mux_rr_arbiter_if #(.W(W)) bus ();

  mux_rr_arbiter #(.W(W), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: owner is the granted source index or -1 when idle.
  int           m_owner;
  int           m_ptr;
  int           m_hold;
  logic [3:0]   e_grant;
  logic [1:0]   e_sel;
  logic [W-1:0] e_y;
  logic         e_yv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] dsrc(input int i);
    case (i)
      0: return bus.D0;
      1: return bus.D1;
      2: return bus.D2;
      default: return bus.D3;
    endcase
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    e_grant = '0;
    e_sel   = '0;
    e_y     = '0;
    e_yv    = 1'b0;
  endtask

  task automatic model_edge();
    bit leave;
    bit found;
    int c;
    if (reset) begin
      model_reset();
      return;
    end
    if (m_owner >= 0) begin
      e_y  = dsrc(m_owner);
      e_yv = 1'b1;
    end else begin
      e_y  = '0;
      e_yv = 1'b0;
    end
    if (m_owner < 0) begin
      m_hold = 0;
      found  = 0;
      for (int k = 0; k < 4; k++) begin
        c = (m_ptr + k) % 4;
        if (!found && bus.req[c]) begin
          found   = 1;
          m_owner = c;
          m_ptr   = (c + 1) % 4;
        end
      end
    end else begin
      leave = !bus.req[m_owner];
`ifdef MUX_ARB_TIMEOUT_EN
      if (m_hold + 1 >= int'(MH)) leave = 1;
`endif
      if (leave) begin
        m_owner = -1;
        m_hold  = 0;
      end else begin
        m_hold++;
      end
    end
    e_grant = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e_sel   = (m_owner < 0) ? 2'd0 : m_owner[1:0];
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".grant"},   32'(bus.grant),   32'(e_grant));
    chk({tag, ".sel"},     32'(bus.sel),     32'(e_sel));
    chk({tag, ".Y"},       32'(bus.Y),       32'(e_y));
    chk({tag, ".y_valid"}, 32'(bus.y_valid), 32'(e_yv));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs({tag, ".async"});
    chk({tag, ".grant0"}, 32'(bus.grant), 32'd0);
    chk({tag, ".yv0"},    32'(bus.y_valid), 32'd0);
    tick({tag, ".hold"});
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    bus.req = '0;
    bus.D0  = '0;
    bus.D1  = '0;
    bus.D2  = '0;
    bus.D3  = '0;
    model_reset();
    #1;
    check_outputs("reset");
    tick("reset_hold");
    reset = 1'b0;

    // Single requester held for five sampled edges.
    bus.D0  = 4'hA;
    bus.D1  = 4'h1;
    bus.D2  = 4'h2;
    bus.D3  = 4'h3;
    bus.req = 4'b0001;
    tick("r030_e1");
    chk("r030_grant_e1", 32'(bus.grant), 32'h1);
    chk("r030_yv_e1",    32'(bus.y_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick("r030_hold");
      chk("r030_Y",  32'(bus.Y), 32'hA);
      chk("r030_yv", 32'(bus.y_valid), 32'd1);
    end
    bus.req = '0;
    tick("r030_drop");
    chk("r030_grant_drop", 32'(bus.grant), 32'd0);
    tick("r030_tail");
    chk("r030_yv_tail", 32'(bus.y_valid), 32'd0);

    // Full contention, each owner releasing after two grant cycles.
    do_reset("r031_rst");
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      tick("r031_win");
      chk("r031_order", 32'(bus.grant), 32'(4'b0001 << (g % 4)));
      tick("r031_hold");
      bus.req = 4'b1111 & ~(4'b0001 << (g % 4));
      tick("r031_rel");
      chk("r031_gap", 32'(bus.grant), 32'd0);
      bus.req = 4'b1111;
    end

    // No preemption of an active grant.
    do_reset("r032_rst");
    bus.req = 4'b0001;
    tick("r032_g0");
    chk("r032_g0_grant", 32'(bus.grant), 32'h1);
    bus.req = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      tick("r032_keep");
      chk("r032_keep_grant", 32'(bus.grant), 32'h1);
    end
    bus.req = 4'b0010;
    tick("r032_gap");
    chk("r032_gap_grant", 32'(bus.grant), 32'd0);
    tick("r032_g1");
    chk("r032_g1_grant", 32'(bus.grant), 32'h2);

    // Reset in the middle of a grant to source 2; ptr must restart at 0.
    do_reset("r033_pre");
    bus.D2  = 4'h5;
    bus.req = 4'b0100;
    tick("r033_g2");
    chk("r033_g2_grant", 32'(bus.grant), 32'h4);
    tick("r033_mid");
    chk("r033_mid_Y", 32'(bus.Y), 32'h5);
    do_reset("r033_abort");
    chk("r033_sel0", 32'(bus.sel), 32'd0);
    chk("r033_Y0",   32'(bus.Y), 32'd0);
    bus.req = 4'b1100;
    tick("r033_after");
    chk("r033_after_grant", 32'(bus.grant), 32'h4);
    chk("r033_after_sel",   32'(bus.sel), 32'd2);

`ifdef MUX_ARB_TIMEOUT_EN
    // Timeout alternation between sources 0 and 2.
    do_reset("r034_rst");
    bus.req = 4'b0101;
    for (int c = 0; c < 16; c++) begin
      tick("r034");
      case (c % 8)
        0, 1, 2: chk("r034_pat", 32'(bus.grant), 32'h1);
        4, 5, 6: chk("r034_pat", 32'(bus.grant), 32'h4);
        default: chk("r034_pat", 32'(bus.grant), 32'd0);
      endcase
    end
`else
    // Grant held indefinitely without the timeout.
    do_reset("r035_rst");
    bus.req = 4'b0001;
    for (int c = 0; c < 50; c++) begin
      tick("r035");
      chk("r035_grant", 32'(bus.grant), 32'h1);
    end
`endif

    // Random traffic with occasional asynchronous resets.
    do_reset("rand_rst");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 35) bus.req = 4'($urandom());
      bus.D0 = W'($urandom());
      bus.D1 = W'($urandom());
      bus.D2 = W'($urandom());
      bus.D3 = W'($urandom());
      if ($urandom_range(0, 59) == 0) do_reset("rand_arst");
      else tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter W, default 4: data width of each source and of the output.
REQ-002 Parameter MAX_HOLD, default 8: maximum consecutive GRANT cycles; used only with the timeout feature.
REQ-003 The block SHALL use one clock; reset SHALL be asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  4  level request per source, bit i = source Di.
REQ-007 D0, D1, D2, D3  input  W each  source data.
REQ-008 grant  output  4  registered one-hot grant, all-zero when idle.
REQ-009 sel  output  2  registered index of the granted source, 0 when idle.
REQ-010 Y  output  W  registered data of the granted source.
REQ-011 y_valid  output  1  registered; high when Y carries granted data.

Function
REQ-012 FSM states: IDLE and GRANT; there SHALL be no other states.
REQ-013 IDLE with req==0: stay in IDLE; grant=0, sel=0.
REQ-014 IDLE with req!=0: pick the first set bit searching upward from ptr, wrapping from 3 to 0; next cycle state=GRANT, grant/sel set to the winner, ptr=winner+1 mod 4.
REQ-015 Latency: req rising at edge n gives grant at edge n+1 and y_valid/Y at edge n+2.
REQ-016 GRANT while req[sel]==1: hold grant and sel unchanged; other requests are ignored (no preemption).
REQ-017 GRANT with req[sel]==0 at an edge: go to IDLE and clear grant/sel at that edge; there SHALL be a minimum one-cycle IDLE gap between grants.
REQ-018 Y SHALL be loaded with D[sel] at every edge where state==GRANT, and with 0 otherwise; y_valid follows the same rule.
REQ-019 Simultaneous release by the granted source and new requests: the FSM goes to IDLE first, and arbitration uses the updated ptr.
REQ-020 The ptr wrap SHALL be modulo 4 (3+1=0).
REQ-021 A source that drops req before it is granted SHALL lose its turn; there SHALL be no request latching.

Reset
REQ-022 On reset assertion, regardless of the clock: state=IDLE, ptr=0, hold counter=0, grant=0, sel=0, Y=0, y_valid=0.
REQ-023 Reset during GRANT SHALL abort the transfer immediately, and after reset release the first arbitration SHALL start from ptr=0.

Configuration
REQ-024 Macro MUX_ARB_TIMEOUT_EN defined: a hold counter SHALL count GRANT cycles; after MAX_HOLD consecutive GRANT cycles the FSM SHALL go to IDLE even if req[sel]==1, and the counter SHALL clear on every IDLE cycle.
REQ-025 With MUX_ARB_TIMEOUT_EN defined, a timed-out source that is the only requester SHALL be re-granted after the one-cycle IDLE gap.
REQ-026 MUX_ARB_TIMEOUT_EN undefined: no counter SHALL be synthesized, MAX_HOLD SHALL be ignored, and the grant SHALL be held indefinitely.

Structure
REQ-027 The state encodings (IDLE=0, GRANT=1) and the MAX_HOLD default SHALL live in the shared include file mux_arb_pkg.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req[3:0] and ptr[1:0]; outputs idx[1:0] and any), instantiated once.
REQ-029 Data selection SHALL be a 4-way W-bit case on sel inside the top module.

Verification
REQ-030 Reset, then req=0001 held for 5 cycles with D0=4'hA: grant=0001 at edge 1; Y=A and y_valid=1 from edge 2 through the hold; grant=0 one edge after req drops.
REQ-031 req=1111 held; each source releases after 2 GRANT cycles and re-raises req: grant order SHALL be 0001, 0010, 0100, 1000, 0001, with an IDLE gap between each.
REQ-032 Source 0 granted, then req=0011: no preemption; when bit 0 drops, source 1 SHALL be granted after one IDLE cycle.
REQ-033 Assert reset mid-GRANT on source 2: all outputs SHALL be 0 in the same cycle; after release with req=1100, source 2 SHALL win (ptr=0).
REQ-034 With MUX_ARB_TIMEOUT_EN and MAX_HOLD=3, req=0101 held: grant=0001 for 3 cycles, 1 IDLE cycle, then grant=0100 for 3 cycles, repeating.
REQ-035 Without MUX_ARB_TIMEOUT_EN, req=0001 held for 50 cycles: grant SHALL stay 0001 for all 50 cycles.
